// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// through a registered borrow. Reports difference, final borrow-out and
// signed overflow together with a one-cycle done strobe.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             br;
   logic [CW-1:0]    cnt;

   logic a0, b0, d, bnext;

   // Full-subtractor difference bit.
   function automatic logic fs_diff(input logic x, input logic y, input logic bi);
      return x ^ y ^ bi;
   endfunction

   // Full-subtractor borrow-out.
   function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
      return (~x & y) | (~(x ^ y) & bi);
   endfunction

   // Overflow test evaluated on the MSB bit slice.
   function automatic logic msb_ovf(input logic x, input logic y, input logic dbit);
      return (x ^ y) & (dbit ^ x);
   endfunction

   // Current bit slice of the serial datapath.
   always_comb begin
      a0    = a_sh[0];
      b0    = b_sh[0];
      d     = fs_diff(a0, b0, br);
      bnext = fs_borrow(a0, b0, br);
   end

   assign busy = (state != IDLE);

   // Control FSM and serial datapath; reset clears everything and aborts a run.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         done  <= 1'b0;
         diff  <= '0;
         bout  <= 1'b0;
         ovf   <= 1'b0;
         a_sh  <= '0;
         b_sh  <= '0;
         br    <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a_in;
                  b_sh  <= b_in;
                  br    <= bin_in;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               diff <= {d, diff[WIDTH-1:1]};
               a_sh <= a_sh >> 1;
               b_sh <= b_sh >> 1;
               br   <= bnext;
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  bout  <= bnext;
                  ovf   <= msb_ovf(a0, b0, d);
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH = 2, 8 and 33.
module tb_serial_subtractor;

   typedef struct packed {
      logic [63:0] diff;
      logic        bout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        st [3];
   logic [63:0] av [3];
   logic [63:0] bv [3];
   logic        bi [3];
   logic        busy_v [3];
   logic        done_v [3];
   logic        bout_v [3];
   logic        ovf_v  [3];
   logic [1:0]  d0;
   logic [7:0]  d1;
   logic [32:0] d2;
   logic [63:0] dv [3];

   int tests = 0;
   int fails = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   assign dv[0] = 64'(d0);
   assign dv[1] = 64'(d1);
   assign dv[2] = 64'(d2);

   serial_subtractor #(.WIDTH(2)) u_w2 (
      .clk(clk), .rst(rst), .start(st[0]), .a_in(av[0][1:0]), .b_in(bv[0][1:0]),
      .bin_in(bi[0]), .busy(busy_v[0]), .done(done_v[0]), .diff(d0),
      .bout(bout_v[0]), .ovf(ovf_v[0]));

   serial_subtractor #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(st[1]), .a_in(av[1][7:0]), .b_in(bv[1][7:0]),
      .bin_in(bi[1]), .busy(busy_v[1]), .done(done_v[1]), .diff(d1),
      .bout(bout_v[1]), .ovf(ovf_v[1]));

   serial_subtractor #(.WIDTH(33)) u_w33 (
      .clk(clk), .rst(rst), .start(st[2]), .a_in(av[2][32:0]), .b_in(bv[2][32:0]),
      .bin_in(bi[2]), .busy(busy_v[2]), .done(done_v[2]), .diff(d2),
      .bout(bout_v[2]), .ovf(ovf_v[2]));

   function automatic int wid(input int k);
      return (k == 0) ? 2 : (k == 1) ? 8 : 33;
   endfunction

   function automatic logic [63:0] wmask(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

   // Reference: plain integer arithmetic on the operand values.
   function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                  input logic bin);
      exp_t        e;
      logic [63:0] m;
      logic [65:0] ua, ub;
      longint      sa, sb, r, lim;
      m      = wmask(w);
      ua     = {2'b00, a & m};
      ub     = {2'b00, b & m} + 66'(bin);
      e.diff = ((a & m) - (b & m) - 64'(bin)) & m;
      e.bout = (ua < ub);
      sa     = longint'(a & m);
      sb     = longint'(b & m);
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      r      = sa - sb - longint'(bin);
      lim    = longint'(1) << (w - 1);
      e.ovf  = (r < -lim) || (r > lim - 1);
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic push(input int k, input exp_t e);
      case (k)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endtask

   function automatic int qsize(input int k);
      case (k)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic exp_t pop(input int k);
      case (k)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   // Monitor: every done strobe is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (done_v[k] === 1'b1) begin
               if (qsize(k) == 0) begin
                  chk($sformatf("w%0d_unexpected_done", wid(k)), 64'd1, 64'd0);
               end else begin
                  e = pop(k);
                  chk($sformatf("w%0d_diff", wid(k)), dv[k], e.diff);
                  chk($sformatf("w%0d_bout", wid(k)), 64'(bout_v[k]), 64'(e.bout));
                  chk($sformatf("w%0d_ovf", wid(k)), 64'(ovf_v[k]), 64'(e.ovf));
               end
            end
         end
      end
   end

   // One operation with latency and busy-length checks; called away from clock edges.
   task automatic run_op(input int k, input logic [63:0] a, input logic [63:0] b,
                         input logic bin);
      int w, busy_cnt, done_at;
      w = wid(k);
      av[k] = a & wmask(w);
      bv[k] = b & wmask(w);
      bi[k] = bin;
      st[k] = 1'b1;
      @(posedge clk); #1;
      st[k] = 1'b0;
      av[k] = 64'($urandom);
      bv[k] = 64'($urandom);
      push(k, model(w, a, b, bin));
      busy_cnt = 0;
      done_at  = -1;
      for (int c = 0; c <= w + 3; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (busy_v[k] === 1'b1) busy_cnt++;
         if (done_v[k] === 1'b1 && done_at < 0) done_at = c;
      end
      chk($sformatf("w%0d_done_latency", w), 64'(done_at), 64'(w));
      chk($sformatf("w%0d_busy_cycles", w), 64'(busy_cnt), 64'(w + 1));
   endtask

   initial begin
      int   n;
      exp_t e1;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         st[k] = 1'b1;
         av[k] = 64'h5;
         bv[k] = 64'h3;
         bi[k] = 1'b1;
      end

      // Reset held with start high: everything stays zero.
      repeat (2) begin
         @(posedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            chk("rst_busy", 64'(busy_v[k]), 64'd0);
            chk("rst_done", 64'(done_v[k]), 64'd0);
            chk("rst_diff", dv[k], 64'd0);
            chk("rst_bout", 64'(bout_v[k]), 64'd0);
            chk("rst_ovf", 64'(ovf_v[k]), 64'd0);
         end
      end
      rst = 1'b0;
      for (int k = 0; k < 3; k++) st[k] = 1'b0;
      @(posedge clk); #1;

      // Directed WIDTH=8 vectors.
      run_op(1, 64'h05, 64'h03, 1'b0);
      run_op(1, 64'h03, 64'h05, 1'b0);
      run_op(1, 64'h00, 64'h00, 1'b1);
      run_op(1, 64'h80, 64'h01, 1'b0);
      run_op(1, 64'h7F, 64'hFF, 1'b0);

      // Start held high with operands changed mid-run.
      e1 = model(8, 64'h5A, 64'hC3, 1'b1);
      av[1] = 64'h5A; bv[1] = 64'hC3; bi[1] = 1'b1; st[1] = 1'b1;
      @(posedge clk); #1;
      push(1, e1);
      repeat (3) @(posedge clk);
      #1;
      av[1] = 64'h10; bv[1] = 64'h20; bi[1] = 1'b0;
      push(1, model(8, 64'h10, 64'h20, 1'b0));
      n = 0;
      while (done_v[1] !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("held_first_done_seen", 64'(done_v[1]), 64'd1);
      @(posedge clk); #1;
      chk("held_idle_busy", 64'(busy_v[1]), 64'd0);
      chk("held_idle_diff", dv[1], e1.diff);
      @(posedge clk); #1;
      chk("held_restart_busy", 64'(busy_v[1]), 64'd1);
      chk("held_restart_diff", dv[1], e1.diff);
      chk("held_restart_bout", 64'(bout_v[1]), 64'(e1.bout));
      st[1] = 1'b0;
      n = 0;
      while (busy_v[1] === 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("held_second_finished", 64'(busy_v[1]), 64'd0);

      // Reset during RUN bit 4 aborts without a done strobe.
      av[1] = 64'h33; bv[1] = 64'h11; bi[1] = 1'b0; st[1] = 1'b1;
      @(posedge clk); #1;
      st[1] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", 64'(busy_v[1]), 64'd0);
      chk("abort_done", 64'(done_v[1]), 64'd0);
      chk("abort_diff", dv[1], 64'd0);
      chk("abort_bout", 64'(bout_v[1]), 64'd0);
      chk("abort_ovf", 64'(ovf_v[1]), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(1, 64'hA5, 64'h5A, 1'b1);

      // Boundary and randomised operands for every width.
      for (int k = 0; k < 3; k++) begin
         logic [63:0] m, mn;
         m  = wmask(wid(k));
         mn = 64'd1 << (wid(k) - 1);
         run_op(k, 64'd0, m, 1'b1);
         run_op(k, m, 64'd0, 1'b0);
         run_op(k, mn, 64'd1, 1'b0);
         run_op(k, mn - 64'd1, m, 1'b0);
         for (int i = 0; i < 25; i++) begin
            run_op(k, {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                   1'($urandom));
         end
      end

      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("w%0d_queue_drained", wid(k)), 64'(qsize(k)), 64'd0);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
